// File: rtl/train_sched_pkg.sv
// Shared types and default constants for the training-run scheduler.
package train_sched_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_LOAD,
    ST_RUN,
    ST_DRAIN,
    ST_DONE
  } train_sched_state_t;

  localparam int DEF_NUM_SAMPLES   = 108;
  localparam int DEF_NUM_EPOCHS    = 16;
  localparam int DEF_IDX_W         = 7;
  localparam int DEF_DRAIN_TIMEOUT = 1024;
  localparam int EPOCH_W           = 16;

  // Stream slots: the input-sample stream and the expected-sample stream.
  localparam int NUM_STREAMS = 2;
  localparam int STRM_IN     = 0;
  localparam int STRM_EXP    = 1;

endpackage

// File: rtl/train_idx_counter.sv
// Per-stream sample index: counts handshakes, wraps at NUM_SAMPLES-1 and
// remembers the wrap until cleared at the next epoch start.
module train_idx_counter #(
  parameter int NUM_SAMPLES = 108,
  parameter int IDX_W       = 7
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             clr,
  input  logic             vld,
  input  logic             inc,
  output logic [IDX_W-1:0] idx,
  output logic             fst,
  output logic             wrap,
  output logic             wrapped
);

  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_SAMPLES - 1);

  logic [IDX_W-1:0] idx_reg;
  logic             wrapped_reg;
  logic             last;

  assign last = (idx_reg == LAST_IDX);
  assign wrap = inc & last;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      idx_reg     <= '0;
      wrapped_reg <= 1'b0;
    end else if (clr) begin
      idx_reg     <= '0;
      wrapped_reg <= 1'b0;
    end else if (inc) begin
      idx_reg <= last ? '0 : idx_reg + 1'b1;
      if (last) begin
        wrapped_reg <= 1'b1;
      end
    end
  end

  assign idx     = idx_reg;
  assign wrapped = wrapped_reg;
  assign fst     = vld & (idx_reg == '0);

endmodule

// File: rtl/train_sched.sv
// Training-run scheduler: sequences epochs of sample/expected address streams
// and tracks in-flight results. Optional drain watchdog: TRAIN_SCHED_TIMEOUT_EN.
module train_sched
  import train_sched_pkg::*;
#(
  parameter int NUM_SAMPLES   = DEF_NUM_SAMPLES,
  parameter int NUM_EPOCHS    = DEF_NUM_EPOCHS,
  parameter int IDX_W         = DEF_IDX_W,
  parameter int DRAIN_TIMEOUT = DEF_DRAIN_TIMEOUT
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               start,
  input  logic               load_finish,
  input  logic               freeze,
  output logic               st_data_vld,
  input  logic               st_data_rdy,
  output logic               st_data_fst,
  output logic [IDX_W-1:0]   st_data_idx,
  output logic               expected_vld,
  input  logic               expected_rdy,
  output logic               expected_fst,
  output logic [IDX_W-1:0]   expected_idx,
  input  logic               st_data_out_vld,
  output logic               tap_update_enable,
  output logic               bias_update_enable,
  output logic [EPOCH_W-1:0] epoch,
  output logic               busy,
  output logic               done,
  output logic               err
);

  train_sched_state_t state_reg, state_next;

  logic [IDX_W:0]         outstanding_reg;
  logic [EPOCH_W-1:0]     epoch_reg;
  logic [EPOCH_W-1:0]     epoch_inc;
  logic                   err_reg;
  logic                   upd_en_reg;
  logic                   active;
  logic                   clr_cnt;
  logic                   drain_exit;
  logic                   timeout_hit;
  logic                   wd_hit;
  logic                   ret_ok;
  logic                   ret_bad;

  logic [NUM_STREAMS-1:0] strm_vld;
  logic [NUM_STREAMS-1:0] strm_rdy;
  logic [NUM_STREAMS-1:0] strm_inc;
  logic [NUM_STREAMS-1:0] strm_fst;
  logic [NUM_STREAMS-1:0] strm_wrap;
  logic [NUM_STREAMS-1:0] strm_wrapped;
  logic [IDX_W-1:0]       strm_idx [NUM_STREAMS];

  assign active   = (state_reg == ST_RUN) || (state_reg == ST_DRAIN);
  assign strm_rdy = {expected_rdy, st_data_rdy};

  // vld is a function of registered state only, never of rdy.
  genvar gi;
  generate
    for (gi = 0; gi < NUM_STREAMS; gi++) begin : g_strm
      assign strm_vld[gi] = active & ~strm_wrapped[gi];
      assign strm_inc[gi] = strm_vld[gi] & strm_rdy[gi];

      train_idx_counter #(
        .NUM_SAMPLES (NUM_SAMPLES),
        .IDX_W       (IDX_W)
      ) u_cnt (
        .clk     (clk),
        .reset   (reset),
        .clr     (clr_cnt),
        .vld     (strm_vld[gi]),
        .inc     (strm_inc[gi]),
        .idx     (strm_idx[gi]),
        .fst     (strm_fst[gi]),
        .wrap    (strm_wrap[gi]),
        .wrapped (strm_wrapped[gi])
      );
    end
  endgenerate

`ifdef TRAIN_SCHED_TIMEOUT_EN
  localparam int WD_W = $clog2(DRAIN_TIMEOUT + 1);
  logic [WD_W-1:0] wd_reg;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wd_reg <= '0;
    end else begin
      wd_reg <= (state_reg == ST_DRAIN) ? wd_reg + 1'b1 : '0;
    end
  end

  assign wd_hit = (state_reg == ST_DRAIN) && (wd_reg == WD_W'(DRAIN_TIMEOUT - 1));
`else
  assign wd_hit = 1'b0;
`endif

  assign epoch_inc = epoch_reg + 1'b1;

  always_comb begin
    state_next  = state_reg;
    drain_exit  = 1'b0;
    timeout_hit = 1'b0;
    case (state_reg)
      ST_IDLE:  if (start) state_next = ST_LOAD;
      ST_LOAD:  if (load_finish) state_next = ST_RUN;
      ST_RUN:   if (strm_wrap[STRM_IN]) state_next = ST_DRAIN;
      ST_DRAIN: begin
        // The last expected handshake itself completes the expected stream.
        if ((outstanding_reg == '0) &&
            (strm_wrapped[STRM_EXP] || strm_wrap[STRM_EXP])) begin
          drain_exit = 1'b1;
          state_next = (32'(epoch_inc) < NUM_EPOCHS) ? ST_RUN : ST_DONE;
        end else if (wd_hit) begin
          timeout_hit = 1'b1;
          state_next  = ST_DONE;
        end
      end
      ST_DONE:  state_next = ST_IDLE;
      default:  state_next = ST_IDLE;
    endcase
  end

  assign clr_cnt = ((state_reg == ST_IDLE) && start) ||
                   ((state_next == ST_RUN) && (state_reg != ST_RUN));

  assign ret_ok  = st_data_out_vld && (outstanding_reg != '0);
  assign ret_bad = st_data_out_vld && (outstanding_reg == '0);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_reg       <= ST_IDLE;
      outstanding_reg <= '0;
      epoch_reg       <= '0;
      err_reg         <= 1'b0;
      upd_en_reg      <= 1'b0;
    end else begin
      state_reg  <= state_next;
      upd_en_reg <= active & ~freeze;

      case ({strm_inc[STRM_IN], ret_ok})
        2'b10:   outstanding_reg <= outstanding_reg + 1'b1;
        2'b01:   outstanding_reg <= outstanding_reg - 1'b1;
        default: outstanding_reg <= outstanding_reg;
      endcase

      if (ret_bad || timeout_hit) begin
        err_reg <= 1'b1;
      end

      if ((state_reg == ST_IDLE) && start) begin
        epoch_reg <= '0;
      end else if (drain_exit) begin
        epoch_reg <= epoch_inc;
      end
    end
  end

  assign st_data_vld        = strm_vld[STRM_IN];
  assign st_data_fst        = strm_fst[STRM_IN];
  assign st_data_idx        = strm_idx[STRM_IN];
  assign expected_vld       = strm_vld[STRM_EXP];
  assign expected_fst       = strm_fst[STRM_EXP];
  assign expected_idx       = strm_idx[STRM_EXP];
  assign tap_update_enable  = upd_en_reg;
  assign bias_update_enable = upd_en_reg;
  assign epoch              = epoch_reg;
  assign busy               = (state_reg != ST_IDLE);
  assign done               = (state_reg == ST_DONE);
  assign err                = err_reg;

endmodule

// File: tb/tb_train_sched.sv
// Self-checking bench for train_sched: sample-count reference model compared
// every cycle, plus literal checks of directed scenarios.
module tb_train_sched;

  localparam int NS = 4;
  localparam int NE = 2;
  localparam int IW = 3;
  localparam int TO = 8;

  localparam int P_IDLE  = 0;
  localparam int P_LOAD  = 1;
  localparam int P_RUN   = 2;
  localparam int P_DRAIN = 3;
  localparam int P_DONE  = 4;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          reset = 1'b1;
  logic          start = 1'b0, load_finish = 1'b0, freeze = 1'b0;
  logic          st_data_rdy = 1'b1, expected_rdy = 1'b1, st_data_out_vld = 1'b0;
  logic          st_data_vld, st_data_fst, expected_vld, expected_fst;
  logic [IW-1:0] st_data_idx, expected_idx;
  logic          tap_update_enable, bias_update_enable, busy, done, err;
  logic [15:0]   epoch;

  train_sched #(
    .NUM_SAMPLES   (NS),
    .NUM_EPOCHS    (NE),
    .IDX_W         (IW),
    .DRAIN_TIMEOUT (TO)
  ) dut (
    .clk                (clk),
    .reset              (reset),
    .start              (start),
    .load_finish        (load_finish),
    .freeze             (freeze),
    .st_data_vld        (st_data_vld),
    .st_data_rdy        (st_data_rdy),
    .st_data_fst        (st_data_fst),
    .st_data_idx        (st_data_idx),
    .expected_vld       (expected_vld),
    .expected_rdy       (expected_rdy),
    .expected_fst       (expected_fst),
    .expected_idx       (expected_idx),
    .st_data_out_vld    (st_data_out_vld),
    .tap_update_enable  (tap_update_enable),
    .bias_update_enable (bias_update_enable),
    .epoch              (epoch),
    .busy               (busy),
    .done               (done),
    .err                (err)
  );

  int vectors = 0;
  int miscompares = 0;

  task automatic chk(input string nm, input int act, input int exp);
    vectors++;
    if (act != exp) begin
      miscompares++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // Reference model: counts of samples issued/expected this epoch, results in flight.
  int m_phase, m_in, m_ex, m_pend, m_epoch, m_wd;
  bit m_err, m_en;
  bit m_active, m_st_vld, m_ex_vld, m_st_hs, m_ex_hs;
  int m_st_idx, m_ex_idx;

  always_comb begin
    m_active = (m_phase == P_RUN) || (m_phase == P_DRAIN);
    m_st_vld = m_active && (m_in < NS);
    m_ex_vld = m_active && (m_ex < NS);
    m_st_idx = m_in % NS;
    m_ex_idx = m_ex % NS;
    m_st_hs  = m_st_vld && st_data_rdy;
    m_ex_hs  = m_ex_vld && expected_rdy;
  end

  always @(posedge clk or posedge reset) begin
    if (reset) begin
      m_phase <= P_IDLE; m_in <= 0; m_ex <= 0; m_pend <= 0;
      m_epoch <= 0; m_wd <= 0; m_err <= 1'b0; m_en <= 1'b0;
    end else begin
      m_en   <= m_active && !freeze;
      if (st_data_out_vld && m_pend == 0) m_err <= 1'b1;
      m_pend <= m_pend + (m_st_hs ? 1 : 0) - ((st_data_out_vld && m_pend != 0) ? 1 : 0);
      m_in   <= m_in + (m_st_hs ? 1 : 0);
      m_ex   <= m_ex + (m_ex_hs ? 1 : 0);
      m_wd   <= (m_phase == P_DRAIN) ? m_wd + 1 : 0;
      case (m_phase)
        P_IDLE: if (start) begin
          m_phase <= P_LOAD; m_epoch <= 0; m_in <= 0; m_ex <= 0;
        end
        P_LOAD: if (load_finish) begin
          m_phase <= P_RUN; m_in <= 0; m_ex <= 0;
        end
        P_RUN: if (m_st_hs && m_in == NS - 1) m_phase <= P_DRAIN;
        P_DRAIN: begin
          if (m_pend == 0 && (m_ex == NS || (m_ex_hs && m_ex == NS - 1))) begin
            m_epoch <= m_epoch + 1;
            m_phase <= (m_epoch + 1 < NE) ? P_RUN : P_DONE;
            m_in <= 0; m_ex <= 0;
          end
`ifdef TRAIN_SCHED_TIMEOUT_EN
          else if (m_wd == TO - 1) begin
            m_phase <= P_DONE; m_err <= 1'b1;
          end
`endif
        end
        default: m_phase <= P_IDLE;
      endcase
    end
  end

  int done_cnt = 0;
  always @(negedge clk) begin
    if (done) done_cnt++;
    chk("st_data_vld",  int'(st_data_vld),  int'(m_st_vld));
    chk("st_data_idx",  int'(st_data_idx),  m_st_idx);
    chk("st_data_fst",  int'(st_data_fst),  int'(m_st_vld && m_st_idx == 0));
    chk("expected_vld", int'(expected_vld), int'(m_ex_vld));
    chk("expected_idx", int'(expected_idx), m_ex_idx);
    chk("expected_fst", int'(expected_fst), int'(m_ex_vld && m_ex_idx == 0));
    chk("tap_en",       int'(tap_update_enable),  int'(m_en));
    chk("bias_en",      int'(bias_update_enable), int'(m_en));
    chk("epoch",        int'(epoch), m_epoch);
    chk("busy",         int'(busy),  int'(m_phase != P_IDLE));
    chk("done",         int'(done),  int'(m_phase == P_DONE));
    chk("err",          int'(err),   int'(m_err));
  end

  // Stimulus state
  int cyc = 0;
  int st_mode = 0, ex_mode = 0, ret_delay = 3;
  bit ret_rand = 1'b0, ret_en = 1'b1, rand_ctl = 1'b0;
  int ret_q[$];
  int iss_idx[$];
  int iss_fst[$];

  task automatic tick();
    @(negedge clk);
    if (st_data_vld && st_data_rdy) begin
      iss_idx.push_back(int'(st_data_idx));
      iss_fst.push_back(int'(st_data_fst));
      ret_q.push_back(cyc + (ret_rand ? int'($urandom_range(1, 6)) : ret_delay));
    end
    @(posedge clk);
    #1;
    cyc++;
    st_data_out_vld = 1'b0;
    if (ret_en && ret_q.size() > 0 && ret_q[0] <= cyc) begin
      void'(ret_q.pop_front());
      st_data_out_vld = 1'b1;
    end
    case (st_mode)
      0:       st_data_rdy = 1'b1;
      1:       st_data_rdy = ~st_data_rdy;
      default: st_data_rdy = 1'($urandom_range(0, 1));
    endcase
    case (ex_mode)
      0:       expected_rdy = 1'b1;
      1:       expected_rdy = ~expected_rdy;
      default: expected_rdy = 1'($urandom_range(0, 1));
    endcase
    if (rand_ctl) begin
      start       = ($urandom_range(0, 15) == 0);
      load_finish = 1'($urandom_range(0, 1));
      if ($urandom_range(0, 7) == 0) freeze = ~freeze;
    end
  endtask

  task automatic start_run();
    start = 1'b1; tick(); start = 1'b0;
    tick(); tick();
    load_finish = 1'b1; tick(); load_finish = 1'b0;
  endtask

  task automatic finish_run(input int limit);
    int n = 0;
    while (m_phase != P_IDLE && n < limit) begin
      tick();
      n++;
    end
    chk("run_completes_in_budget", int'(m_phase == P_IDLE), 1);
    $display("run finished: epoch=%0d err=%0d cycles=%0d", epoch, err, n);
  endtask

  task automatic chk_seq(input string nm);
    chk({nm, "_count"}, iss_idx.size(), 2 * NS);
    for (int i = 0; i < iss_idx.size() && i < 2 * NS; i++) begin
      chk({nm, "_idx"}, iss_idx[i], i % NS);
      chk({nm, "_fst"}, iss_fst[i], int'(i % NS == 0));
    end
  endtask

  initial begin
    int d0;
    int n;
    tick(); tick();
    chk("reset_busy", int'(busy), 0);
    chk("reset_st_vld", int'(st_data_vld), 0);
    chk("reset_epoch", int'(epoch), 0);
    reset = 1'b0;
    tick();

    // Full run, rdy held high, results 3 cycles after issue
    iss_idx.delete(); iss_fst.delete(); d0 = done_cnt;
    start_run(); finish_run(300);
    chk_seq("basic");
    chk("basic_epoch", int'(epoch), 2);
    chk("basic_done_pulses", done_cnt - d0, 1);

    // Input rdy toggling 1010...
    st_mode = 1;
    iss_idx.delete(); iss_fst.delete();
    start_run(); finish_run(300);
    chk_seq("toggle");
    st_mode = 0; st_data_rdy = 1'b1;

    // One-cycle return latency: return and new issue coincide
    ret_delay = 1;
    start_run(); finish_run(300);
    ret_delay = 3;

    // Freeze mid-run
    iss_idx.delete(); iss_fst.delete();
    start_run(); tick();
    chk("freeze_before", int'(tap_update_enable), 1);
    freeze = 1'b1; tick();
    chk("freeze_tap", int'(tap_update_enable), 0);
    chk("freeze_bias", int'(bias_update_enable), 0);
    finish_run(300);
    chk_seq("freeze");
    freeze = 1'b0;
    tick();

    // Reset during DRAIN
    ret_delay = 20; d0 = done_cnt;
    start_run();
    n = 0;
    while (m_phase != P_DRAIN && n < 100) begin tick(); n++; end
    chk("reached_drain", int'(m_phase == P_DRAIN), 1);
    ret_q.delete();
    reset = 1'b1;
    #1;
    chk("rst_busy", int'(busy), 0);
    chk("rst_vld", int'(st_data_vld | expected_vld), 0);
    chk("rst_en", int'(tap_update_enable | bias_update_enable), 0);
    chk("rst_done", int'(done), 0);
    tick(); tick();
    reset = 1'b0;
    tick(); tick();
    chk("rst_no_done_pulse", done_cnt - d0, 0);
    ret_delay = 3;

    // Randomized traffic
    st_mode = 2; ex_mode = 2; ret_rand = 1'b1; rand_ctl = 1'b1;
    for (int i = 0; i < 2500; i++) tick();
    rand_ctl = 1'b0; start = 1'b0; load_finish = 1'b1; freeze = 1'b0;
    finish_run(3000);
    load_finish = 1'b0;
    for (int i = 0; i < 10; i++) tick();
    st_mode = 0; ex_mode = 0; ret_rand = 1'b0;
    tick();

    // Stray result with nothing outstanding
    chk("err_before", int'(err), 0);
    tick();
    st_data_out_vld = 1'b1;
    tick();
    chk("err_after_stray", int'(err), 1);

`ifdef TRAIN_SCHED_TIMEOUT_EN
    // Watchdog: no results ever returned
    reset = 1'b1; tick(); reset = 1'b0; tick();
    ret_en = 1'b0; ret_q.delete(); d0 = done_cnt;
    start_run(); finish_run(300);
    chk("timeout_err", int'(err), 1);
    chk("timeout_done_pulses", done_cnt - d0, 1);
    chk("timeout_epoch", int'(epoch), 0);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/train_sched.md
TRAIN_SCHED -- requirements
Module: train_sched

Interface
REQ-001 SHALL have parameter NUM_SAMPLES, default 108, samples per epoch.
REQ-002 SHALL have parameter NUM_EPOCHS, default 16, epochs per run.
REQ-003 SHALL have parameter IDX_W, default 7, sample index width; NUM_SAMPLES <= 2**IDX_W.
REQ-004 SHALL have parameter DRAIN_TIMEOUT, default 1024, drain watchdog limit in cycles (used only under TRAIN_SCHED_TIMEOUT_EN).
REQ-005 SHALL have ports `clk`, input, 1, the single clock; all state SHALL be in this clock domain.
REQ-006 SHALL have port `reset`, input, 1, asynchronous active-high reset.
REQ-007 SHALL have ports start in 1 (run request pulse); load_finish in 1 (taps loaded); freeze in 1 (inference only, no updates).
REQ-008 SHALL have ports st_data_vld out 1; st_data_rdy in 1; st_data_fst out 1; st_data_idx out IDX_W (input sample address).
REQ-009 SHALL have ports expected_vld out 1; expected_rdy in 1; expected_fst out 1; expected_idx out IDX_W (expected sample address).
REQ-010 SHALL have port st_data_out_vld in 1, one pulse per completed result.
REQ-011 SHALL have ports tap_update_enable out 1; bias_update_enable out 1; epoch out 16; busy out 1; done out 1; err out 1.

Function
REQ-012 States: IDLE, LOAD, RUN, DRAIN, DONE.
REQ-013 IDLE->LOAD on start; start in any other state SHALL be ignored.
REQ-014 LOAD->RUN on the cycle load_finish=1; LOAD holds otherwise.
REQ-015 In RUN, st_data_vld=1 and expected_vld=1; each stream's index advances only on its own vld&rdy.
REQ-016 Each index wraps NUM_SAMPLES-1 -> 0 and its stream vld SHALL drop after the wrap until the next epoch starts.
REQ-017 *_fst SHALL be 1 exactly when its index is 0 and vld=1.
REQ-018 RUN->DRAIN on the cycle the input stream wraps.
REQ-019 Outstanding counter, width IDX_W+1: +1 on input handshake, -1 on st_data_out_vld, unchanged when both occur in the same cycle.
REQ-020 st_data_out_vld while outstanding=0 SHALL be ignored and set err (sticky until reset).
REQ-021 DRAIN exit requires outstanding=0 and the expected stream wrapped; then epoch+1, and next state is RUN if epoch+1 < NUM_EPOCHS, else DONE.
REQ-022 DONE: done=1 for exactly one cycle, then IDLE; epoch SHALL hold its final value until the next start, which clears it to 0.
REQ-023 busy=1 in every state except IDLE.
REQ-024 tap_update_enable = bias_update_enable = (state in RUN or DRAIN) and not freeze; both are registered, so they lag freeze by 1 cycle.
REQ-025 Handshake latency: an index update SHALL be visible the cycle after its handshake; vld SHALL never depend combinationally on rdy.

Reset
REQ-026 Reset SHALL be asynchronous: state=IDLE, indices=0, outstanding=0, epoch=0, err=0.
REQ-027 While reset is asserted, all vld, fst, enable, busy and done outputs SHALL be 0.
REQ-028 Reset asserted mid-RUN or mid-DRAIN SHALL abort the run with no done pulse.

Configuration
REQ-029 With TRAIN_SCHED_TIMEOUT_EN defined, a DRAIN lasting DRAIN_TIMEOUT cycles SHALL set err and force DONE (done still pulses).
REQ-030 Without TRAIN_SCHED_TIMEOUT_EN, DRAIN SHALL wait indefinitely, and no watchdog counter is synthesized.

Structure
REQ-031 The shared package SHALL hold train_sched_state_t (state enum) and default constants for sample count, epoch count and timeout.
REQ-032 Sub-module train_idx_counter (wrap counter with inc, wrap flag and fst) SHALL be instantiated twice, once per stream.

Verification
REQ-033 NUM_SAMPLES=4, NUM_EPOCHS=2, rdy held 1, results returned 3 cycles after issue -> indices 0,1,2,3,0,1,2,3; fst on each 0; done pulses once; epoch=2.
REQ-034 st_data_rdy toggling 1010... -> st_data_idx advances only on handshake cycles; no sample index skipped or repeated.
REQ-035 Result return and a new issue in the same cycle -> outstanding count unchanged; extra return with outstanding=0 -> err=1.
REQ-036 freeze asserted mid-RUN -> both update enables 0 one cycle later; indexing continues unaffected.
REQ-037 Reset asserted during DRAIN -> next cycle state IDLE, all outputs 0, done never pulses.
REQ-038 TRAIN_SCHED_TIMEOUT_EN defined, DRAIN_TIMEOUT=8, no result returns -> after 8 DRAIN cycles err=1 and done pulses.
